snake_move_ctrl: RTL and testbench

//  Sequencer for the snake body-update datapath. Generates the periodic move `pulse` and the restart `sync`.

---
 rtl/snake_pkg.sv | 38 +++
 rtl/snake_dir_fifo.sv | 61 ++++++
 rtl/snake_move_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_snake_move_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// snake_pkg: direction and game-state encodings shared by the
// snake move controller and its direction FIFO.
package snake_pkg;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } state_t;

  localparam int DIR_FIFO_DEPTH = 2;

  function automatic dir_t opposite(input dir_t d);
    dir_t r;
    case (d)
      DIR_UP:    r = DIR_DOWN;
      DIR_DOWN:  r = DIR_UP;
      DIR_LEFT:  r = DIR_RIGHT;
      DIR_RIGHT: r = DIR_LEFT;
      default:   r = DIR_NONE;
    endcase
    return r;
  endfunction

  function automatic logic dir_legal(input logic [2:0] d);
    return (d != 3'd0) && (d <= 3'd4);
  endfunction

endpackage

// File: rtl/snake_dir_fifo.sv
// snake_dir_fifo: 2-entry turn buffer between player input and the
// move tick. Push and pop in one cycle are both honoured.
module snake_dir_fifo
  import snake_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_push,
  input  logic i_pop,
  input  logic i_flush,
  input  dir_t i_din,
  output dir_t o_head,
  output dir_t o_tail,
  output logic o_full,
  output logic o_empty
);

  dir_t       r_mem [DIR_FIFO_DEPTH];
  logic [1:0] r_cnt;
  logic       w_push;
  logic       w_pop;

  assign o_empty = (r_cnt == 2'd0);
  assign o_full  = (r_cnt == 2'd2);
  assign o_head  = r_mem[0];
  assign o_tail  = o_full ? r_mem[1] : r_mem[0];

  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= 2'd0;
      r_mem[0] <= DIR_NONE;
      r_mem[1] <= DIR_NONE;
    end else if (i_flush) begin
      r_cnt <= 2'd0;
    end else begin
      unique case ({w_push, w_pop})
        2'b10: begin
          r_mem[r_cnt[0]] <= i_din;
          r_cnt           <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_mem[0] <= r_mem[1];
          r_cnt    <= r_cnt - 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r_mem[0] <= i_din;
          end else begin
            r_mem[0] <= r_mem[1];
            r_mem[1] <= i_din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/snake_move_ctrl.sv
// snake_move_ctrl: move tick, restart strobe, turn filter, length and
// game FSM. Define SNAKE_SPEEDUP_EN to shorten the tick as the snake grows.
module snake_move_ctrl
  import snake_pkg::*;
#(
  parameter int MAX_LENGTH  = 50,
  parameter int INIT_LENGTH = 3,
  parameter int TICK_CYCLES = 2_500_000,
  parameter int CNT_W       = 22
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic [2:0] dir_req,
  input  logic       dir_req_valid,
  input  logic       grow,
  input  logic       collide,
  output logic       pulse,
  output logic       sync,
  output logic [2:0] direction,
  output logic [7:0] curr_length,
  output logic [1:0] game_state,
  output logic       game_over
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;

  localparam logic [7:0] LEN_INIT = 8'(INIT_LENGTH);
  localparam logic [7:0] LEN_SAT  = 8'(MAX_LENGTH - 1);

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_last;
  logic             r_pulse;
  logic             r_sync;
  logic             r_grow_pend;
  dir_t             r_dir;
  logic [7:0]       r_len;

  logic w_init;
  logic w_run;
  logic w_play;
  logic w_adv;
  logic w_tick;
  logic w_grow_now;
  logic w_push;
  logic w_full;
  logic w_empty;
  dir_t w_req;
  dir_t w_ref;
  dir_t w_head;
  dir_t w_tail;

  assign w_init = (r_state == S_INIT);
  assign w_run  = (r_state == S_RUN);
  assign w_play = w_run || (r_state == S_PAUSE);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_INIT;
      S_INIT:  w_state_nxt = S_RUN;
      S_RUN: begin
        if (collide)    w_state_nxt = S_OVER;
        else if (pause) w_state_nxt = S_PAUSE;
      end
      S_PAUSE: begin
        if (start)      w_state_nxt = S_INIT;
        else if (pause) w_state_nxt = S_RUN;
      end
      S_OVER:  if (start) w_state_nxt = S_INIT;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sync  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sync  <= (w_state_nxt == S_INIT);
    end
  end

  // A cycle that leaves RUN neither counts nor ticks, so collide beats the tick.
  assign w_adv  = w_run && !collide && !pause;
  assign w_tick = w_adv && (r_cnt == w_last);

`ifdef SNAKE_SPEEDUP_EN
  localparam int STEP  = TICK_CYCLES >> 6;
  localparam int FLOOR = TICK_CYCLES >> 2;

  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] w_period_nxt;
  logic [31:0]      w_dec;

  always_comb begin
    w_dec = 32'(r_len - LEN_INIT) * 32'(STEP);
    if (w_dec > 32'(TICK_CYCLES - FLOOR))
      w_period_nxt = CNT_W'(FLOOR);
    else
      w_period_nxt = CNT_W'(32'(TICK_CYCLES) - w_dec);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_period <= CNT_W'(TICK_CYCLES);
    else if (w_init) r_period <= CNT_W'(TICK_CYCLES);
    else if (w_tick) r_period <= w_period_nxt;
  end

  assign w_last = r_period - CNT_W'(1);
`else
  assign w_last = CNT_W'(TICK_CYCLES - 1);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= w_tick;
      if (w_init || w_tick) r_cnt <= '0;
      else if (w_adv)       r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Turns are checked against the last queued turn, not the live heading.
  assign w_req  = dir_t'(dir_req);
  assign w_ref  = w_empty ? r_dir : w_tail;
  assign w_push = dir_req_valid && w_play && dir_legal(dir_req) &&
                  (w_req != w_ref) && (w_req != opposite(w_ref)) &&
                  !w_full;

  snake_dir_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (r_pulse),
    .i_flush (w_init),
    .i_din   (w_req),
    .o_head  (w_head),
    .o_tail  (w_tail),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_grow_now = grow && w_run;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dir       <= DIR_NONE;
      r_len       <= 8'd0;
      r_grow_pend <= 1'b0;
    end else if (w_init) begin
      r_dir       <= DIR_RIGHT;
      r_len       <= LEN_INIT;
      r_grow_pend <= 1'b0;
    end else if (r_pulse) begin
      if (!w_empty) r_dir <= w_head;
      if ((r_grow_pend || w_grow_now) && (r_len < LEN_SAT))
        r_len <= r_len + 8'd1;
      r_grow_pend <= 1'b0;
    end else if (w_grow_now) begin
      r_grow_pend <= 1'b1;
    end
  end

  always_comb begin
    game_state = IDLE;
    unique case (1'b1)
      w_init || w_run:      game_state = RUN;
      (r_state == S_PAUSE): game_state = PAUSE;
      (r_state == S_OVER):  game_state = OVER;
      default:              game_state = IDLE;
    endcase
  end

  assign pulse       = r_pulse;
  assign sync        = r_sync;
  assign direction   = r_dir;
  assign curr_length = r_len;
  assign game_over   = (r_state == S_OVER);

endmodule

// File: tb/tb_snake_move_ctrl.sv
// tb_snake_move_ctrl: directed scenarios plus random play, checked
// cycle by cycle against a queue-based behavioural game model.
module tb_snake_move_ctrl;

  localparam int TICK  = 8;
  localparam int MAXL  = 50;
  localparam int INITL = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, pause, dir_req_valid, grow, collide;
  logic [2:0] dir_req;
  logic       pulse, sync, game_over;
  logic [2:0] direction;
  logic [7:0] curr_length;
  logic [1:0] game_state;

  always #5 clk = ~clk;

  snake_move_ctrl #(
    .MAX_LENGTH  (MAXL),
    .INIT_LENGTH (INITL),
    .TICK_CYCLES (TICK),
    .CNT_W       (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .pause         (pause),
    .dir_req       (dir_req),
    .dir_req_valid (dir_req_valid),
    .grow          (grow),
    .collide       (collide),
    .pulse         (pulse),
    .sync          (sync),
    .direction     (direction),
    .curr_length   (curr_length),
    .game_state    (game_state),
    .game_over     (game_over)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model of the game.
  typedef enum {M_IDLE, M_INIT, M_RUN, M_PAUSE, M_OVER} mst_e;
  mst_e m_st;
  int   m_elapsed, m_dir, m_len;
  bit   m_pulse, m_sync, m_pend;
  int   m_q[$];

  function automatic int opp(input int d);
    if (d == 0) return 0;
    return (d % 2 == 1) ? d + 1 : d - 1;
  endfunction

  function automatic int m_gs();
    case (m_st)
      M_IDLE:  return 0;
      M_PAUSE: return 2;
      M_OVER:  return 3;
      default: return 1;
    endcase
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_elapsed = 0; m_dir = 0; m_len = 0;
    m_pulse = 0; m_sync = 0; m_pend = 0; m_q.delete();
  endtask

  task automatic model_step(input bit s, p, dv, input int dr,
                            input bit g, c);
    mst_e ns;
    bit   acc, gnow, npulse;
    int   rf;
    ns = m_st;
    case (m_st)
      M_IDLE:  if (s) ns = M_INIT;
      M_INIT:  ns = M_RUN;
      M_RUN:   if (c) ns = M_OVER; else if (p) ns = M_PAUSE;
      M_PAUSE: if (s) ns = M_INIT; else if (p) ns = M_RUN;
      M_OVER:  if (s) ns = M_INIT;
      default: ns = M_IDLE;
    endcase
    rf  = (m_q.size() != 0) ? m_q[$] : m_dir;
    acc = dv && (m_st == M_RUN || m_st == M_PAUSE) && dr >= 1 && dr <= 4
          && dr != rf && dr != opp(rf) && m_q.size() < 2;
    gnow = g && (m_st == M_RUN);
    npulse = 0;
    if (m_st == M_RUN && !c && !p) begin
      m_elapsed++;
      if (m_elapsed == TICK) begin
        m_elapsed = 0;
        npulse = 1;
      end
    end
    if (m_pulse) begin
      if (m_q.size() != 0) m_dir = m_q.pop_front();
      if (m_pend || gnow) m_len = (m_len + 1 > MAXL - 1) ? MAXL - 1 : m_len + 1;
      m_pend = 0;
    end else if (gnow) begin
      m_pend = 1;
    end
    if (acc) m_q.push_back(dr);
    if (m_st == M_INIT) begin
      m_dir = 4; m_len = INITL; m_q.delete(); m_elapsed = 0; m_pend = 0;
    end
    m_pulse = npulse;
    m_sync  = (ns == M_INIT);
    m_st    = ns;
  endtask

  task automatic cmp_all();
    chk("pulse", pulse, m_pulse);
    chk("sync", sync, m_sync);
    chk("direction", direction, m_dir);
    chk("curr_length", curr_length, m_len);
    chk("game_state", game_state, m_gs());
    chk("game_over", game_over, m_st == M_OVER);
  endtask

  task automatic step(input bit s, p, dv, input int dr, input bit g, c);
    start = s; pause = p; dir_req_valid = dv;
    dir_req = 3'(dr); grow = g; collide = c;
    @(posedge clk);
    model_step(s, p, dv, dr, g, c);
    #1;
    cmp_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic wait_pulse(input int maxc, output int n);
    n = 0;
    do begin
      step(0, 0, 0, 0, 0, 0);
      n++;
    end while (!m_pulse && n < maxc);
    chk("pulse_wait", pulse, 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pulse"}, pulse, 0);
    chk({tag, "_sync"}, sync, 0);
    chk({tag, "_dir"}, direction, 0);
    chk({tag, "_len"}, curr_length, 0);
    chk({tag, "_gs"}, game_state, 0);
    chk({tag, "_over"}, game_over, 0);
  endtask

  task automatic mid_reset();
    #2 rst = 1'b1;
    #1 chk_reset_vals("async_rst");
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; start = 0; pause = 0; dir_req_valid = 0;
    dir_req = 0; grow = 0; collide = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 chk_reset_vals("reset");
    rst = 1'b0;
    idle(2);

    // start: one-cycle sync, then length/direction loaded
    step(1, 0, 0, 0, 0, 0);
    chk("start_sync", sync, 1);
    idle(1);
    chk("sync_once", sync, 0);
    chk("init_len", curr_length, 3);
    chk("init_dir", direction, 4);
    wait_pulse(20, n);
    chk("first_pulse_lat", n, TICK);

    // reversal rejected, then UP, LEFT queued
    step(0, 0, 1, 3, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 3, 0, 0);
    chk("dir_before_tick", direction, 4);
    wait_pulse(20, n);
    idle(1);
    chk("turn_up", direction, 1);
    wait_pulse(20, n);
    idle(1);
    chk("turn_left", direction, 3);

    // third turn dropped; push on pop cycle keeps order
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 4, 0, 0);
    step(0, 0, 1, 2, 0, 0);
    wait_pulse(20, n);
    idle(1);
    chk("fifo_first", direction, 1);
    wait_pulse(20, n);
    step(0, 0, 1, 1, 0, 0);
    chk("fifo_second", direction, 4);
    wait_pulse(20, n);
    idle(1);
    chk("push_on_pop", direction, 1);

    // two grows in one tick count once
    step(0, 0, 0, 0, 1, 0);
    idle(1);
    step(0, 0, 0, 0, 1, 0);
    wait_pulse(20, n);
    idle(1);
    chk("grow_once", curr_length, 4);
    wait_pulse(20, n);
    idle(1);
    chk("grow_no_extra", curr_length, 4);

    // saturate the length
    for (int i = 0; i < 60 && m_len < MAXL - 1; i++) begin
      step(0, 0, 0, 0, 1, 0);
      wait_pulse(20, n);
      idle(1);
    end
    chk("len_reach_max", curr_length, MAXL - 1);
    step(0, 0, 0, 0, 1, 0);
    wait_pulse(20, n);
    idle(1);
    chk("len_saturate", curr_length, MAXL - 1);

    // pause at counter 5 freezes the tick
    idle(4);
    step(0, 1, 0, 0, 0, 0);
    chk("paused_state", game_state, 2);
    idle(3);
    step(0, 1, 0, 0, 0, 0);
    wait_pulse(20, n);
    chk("unpause_lat", n, 3);

    // collide on the tick cycle suppresses the pulse
    idle(7);
    step(0, 0, 0, 0, 0, 1);
    chk("collide_nopulse", pulse, 0);
    chk("collide_over", game_over, 1);
    idle(2);
    chk("over_hold_len", curr_length, MAXL - 1);

    // restart from OVER
    step(1, 0, 0, 0, 0, 0);
    chk("restart_sync", sync, 1);
    idle(1);
    chk("restart_len", curr_length, 3);

    // async reset mid-game
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    idle(2);
    mid_reset();
    idle(12);
    chk("no_sync_after_rst", sync, 0);
    chk("idle_after_rst", game_state, 0);

    // random play
    for (int i = 0; i < 3000; i++) begin
      bit s, p, dv, g, c;
      int dr;
      if ($urandom_range(0, 499) == 0) begin
        mid_reset();
        continue;
      end
      s  = ($urandom_range(0, 99) < 3);
      p  = ($urandom_range(0, 99) < 3);
      dv = ($urandom_range(0, 99) < 30);
      dr = $urandom_range(0, 4);
      g  = ($urandom_range(0, 99) < 10);
      c  = ($urandom_range(0, 199) == 0);
      step(s, p, dv, dr, g, c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
